// File: rtl/decoder_scan.sv
// Registered N-way decoder with manual select or auto-scan through all channels.
// Optional macro DECODER_SCAN_BLANK_EN blanks o_y for the first BLANK cycles of each auto dwell.
module decoder_scan #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_opt,
  output logic [2**SEL_W-1:0]   o_y,
  output logic [SEL_W-1:0]      o_idx,
  output logic                  o_tick
);

  localparam int unsigned N    = 2 ** SEL_W;
  localparam int unsigned CntW = $clog2(DWELL);
  localparam logic [CntW-1:0] CntMax = CntW'(DWELL - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N-1:0]     y_q, y_d;
  logic             tick_q, tick_d;
  logic             active;

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    tick_d = 1'b0;
    active = 1'b0;
    if (!i_en) begin
      // Frozen: index held, dwell restarts in full on re-enable.
      cnt_d = '0;
    end else if (!i_mode) begin
      idx_d  = i_sel;
      cnt_d  = '0;
      active = 1'b1;
    end else begin
      active = 1'b1;
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        idx_d  = idx_q + 1'b1;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`ifdef DECODER_SCAN_BLANK_EN
      if (cnt_d < CntW'(BLANK)) begin
        active = 1'b0;
      end
`endif
    end
  end

`ifndef DECODER_SCAN_BLANK_EN
  logic unused_blank;
  assign unused_blank = (BLANK != 0);
`endif

  always_comb begin
    y_d = {N{~i_opt}};
    if (active) begin
      y_d[idx_d] = i_opt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      y_q    <= '1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      y_q    <= y_d;
      tick_q <= tick_d;
    end
  end

  assign o_y    = y_q;
  assign o_idx  = idx_q;
  assign o_tick = tick_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan (SEL_W=3, DWELL=4, BLANK=1).
module tb_decoder_scan;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [2:0] sel;
  logic       opt;
  logic [7:0] y;
  logic [2:0] idx;
  logic       tick;

  int tests;
  int fails;

`ifdef DECODER_SCAN_BLANK_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif

  decoder_scan #(
    .SEL_W (3),
    .DWELL (4),
    .BLANK (1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_mode  (mode),
    .i_sel   (sel),
    .i_opt   (opt),
    .o_y     (y),
    .o_idx   (idx),
    .o_tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hot(input int i, input logic pol);
    logic [7:0] v;
    v = 8'h01 << i;
    return pol ? v : ~v;
  endfunction

  task automatic check_out(input string tag, input logic [7:0] ey, input logic [2:0] ei,
                           input logic et);
    check({tag, ".y"}, 32'(y), 32'(ey));
    check({tag, ".idx"}, 32'(idx), 32'(ei));
    check({tag, ".tick"}, 32'(tick), 32'(et));
  endtask

  logic [7:0] cold_tab [8];
  logic [7:0] hot_tab  [8];
  logic [2:0] eidx;
  logic [7:0] ey;

  initial begin
    tests = 0;
    fails = 0;
    cold_tab = '{8'hfe, 8'hfd, 8'hfb, 8'hf7, 8'hef, 8'hdf, 8'hbf, 8'h7f};
    hot_tab  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst_n = 1'b1;
    en    = 1'b0;
    mode  = 1'b0;
    sel   = 3'd0;
    opt   = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_out("reset_async", 8'hff, 3'd0, 1'b0);
    step();
    check_out("reset_held", 8'hff, 3'd0, 1'b0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Manual decode, one-cold then one-hot.
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      step();
      check_out($sformatf("manual_cold%0d", i), cold_tab[i], 3'(i), 1'b0);
    end
    opt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      step();
      check_out($sformatf("manual_hot%0d", i), hot_tab[i], 3'(i), 1'b0);
    end

    // Auto scan from idx 6 through the 7->0 wrap, ending mid-dwell on idx 3.
    sel = 3'd6;
    step();
    check_out("scan_start", 8'h40, 3'd6, 1'b0);
    mode = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      eidx = 3'((6 + k / 4) % 8);
      ey   = (BlankEn && (k % 4 == 0)) ? 8'h00 : hot(int'(eidx), 1'b1);
      check_out($sformatf("scan_k%0d", k), ey, eidx, k % 4 == 0);
    end

    // Enable freeze mid-dwell on idx 3.
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_out($sformatf("freeze%0d", k), 8'h00, 3'd3, 1'b0);
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_out($sformatf("resume%0d", k), 8'h08, 3'd3, 1'b0);
    end
    step();
    check_out("resume_adv", BlankEn ? 8'h00 : 8'h10, 3'd4, 1'b1);

    // Asynchronous reset pulled between edges mid-scan.
    step();
    check_out("pre_reset", 8'h10, 3'd4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_out("reset_mid", 8'hff, 3'd0, 1'b0);
    step();
    check_out("reset_mid_held", 8'hff, 3'd0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_out($sformatf("post_reset%0d", k), 8'h01, 3'd0, 1'b0);
    end
    step();
    check_out("post_reset_adv", BlankEn ? 8'h00 : 8'h02, 3'd1, 1'b1);

    // Run on to idx 5, then switch to manual mid-dwell.
    for (int k = 1; k <= 17; k++) begin
      step();
      eidx = 3'(1 + k / 4);
      check($sformatf("run_idx%0d", k), 32'(idx), 32'(eidx));
    end
    mode = 1'b0;
    sel  = 3'd2;
    step();
    check_out("to_manual", 8'h04, 3'd2, 1'b0);

    // Back to auto: idx 2 dwells in full; polarity flip leaves the dwell alone.
    mode = 1'b1;
    step();
    check_out("to_auto1", 8'h04, 3'd2, 1'b0);
    step();
    check_out("to_auto2", 8'h04, 3'd2, 1'b0);
    opt = 1'b0;
    step();
    check_out("opt_flip", 8'hfb, 3'd2, 1'b0);
    step();
    check_out("to_auto_adv", BlankEn ? 8'hff : 8'hf7, 3'd3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 3; select width; N = 2^SEL_W channels.
REQ-002 SHALL have parameter DWELL, default 1000; clock cycles per channel in scan mode; legal range 2..65535.
REQ-003 SHALL have parameter BLANK, default 1; inactive cycles at the start of each dwell (used only with DECODER_SCAN_BLANK_EN); legal range 0..DWELL-1.
REQ-004 SHALL have port i_clk  input  1  system clock, rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_en  input  1  enable; 0 forces all outputs inactive and freezes the scan.
REQ-007 SHALL have port i_mode  input  1  0 = manual (decode i_sel), 1 = auto scan.
REQ-008 SHALL have port i_sel  input  SEL_W  channel index in manual mode.
REQ-009 SHALL have port i_opt  input  1  polarity; 0 = one-cold (active low), 1 = one-hot (active high).
REQ-010 SHALL have port o_y  output  N  registered decoded channel select.
REQ-011 SHALL have port o_idx  output  SEL_W  registered index of the current channel.
REQ-012 SHALL have port o_tick  output  1  one-cycle pulse when the scan advances to the next channel.

Function
REQ-013 SHALL register all outputs; o_y, o_idx and o_tick reflect inputs sampled on the previous rising edge (latency 1 cycle).
REQ-014 SHALL drive the active channel bit of o_y to i_opt and every other bit to ~i_opt; the inactive pattern is all bits = ~i_opt.
REQ-015 SHALL, in manual mode with i_en=1, load idx <= i_sel each cycle and drive o_y for channel i_sel; o_tick = 0; dwell counter held at 0.
REQ-016 SHALL, in auto mode with i_en=1, increment a dwell counter 0..DWELL-1 each cycle; on DWELL-1 the counter returns to 0, idx <= idx+1 modulo N (N-1 wraps to 0), and o_tick = 1 for that one cycle.
REQ-017 SHALL, on switching manual->auto, start scanning from the current idx with the dwell counter at 0; on auto->manual, follow i_sel on the next edge and clear the dwell counter.
REQ-018 SHALL, with i_en=0, hold idx, clear the dwell counter, drive o_y inactive and o_tick = 0; on i_en returning to 1 scanning resumes from the held idx with a full dwell.
REQ-019 SHALL apply a change of i_opt to o_y on the next edge without disturbing idx or the dwell counter.
REQ-020 SHALL treat i_mode, i_en, i_sel and i_opt as synchronous inputs with no internal synchronisers.

Reset
REQ-021 SHALL, while i_rst_n = 0, asynchronously force o_y to all ones, o_idx to 0, o_tick to 0 and the dwell counter to 0.
REQ-022 SHALL, on the first rising edge after reset release, behave per Function using the sampled inputs; reset asserted mid-dwell aborts the dwell, and scanning restarts at channel 0.

Configuration
REQ-023 SHALL, when macro DECODER_SCAN_BLANK_EN is defined, drive o_y inactive in auto mode while the dwell counter < BLANK (o_idx still shows the new channel); blanking is not applied in manual mode.
REQ-024 SHALL, when DECODER_SCAN_BLANK_EN is not defined, omit blanking logic and ignore BLANK; o_y is active for the full dwell.

Verification (SEL_W=3, DWELL=4, BLANK=1)
REQ-025 SHALL check manual decode: i_en=1, i_mode=0, i_opt=0, i_sel=0..7 -> o_y = 8'b1111_1110 .. 8'b0111_1111 one cycle later; i_opt=1 gives the bitwise inverse.
REQ-026 SHALL check scan and wrap: auto from idx 6 -> o_idx 6,7,0,1 each held 4 cycles, o_tick high once per transition, including 7->0.
REQ-027 SHALL check blanking with the macro defined, i_opt=1, auto -> o_y = 8'h00 for the first cycle of each dwell and one-hot for the other 3 cycles; without the macro, one-hot for all 4 cycles.
REQ-028 SHALL check enable freeze: i_en=0 for 10 cycles mid-dwell on idx 3 -> o_y inactive, o_tick = 0, o_idx = 3; after re-enable, idx 3 holds a full 4 cycles.
REQ-029 SHALL check async reset: i_rst_n pulled low between edges mid-scan -> o_y = 8'hff, o_idx = 0 and o_tick = 0 immediately; after release, auto scan starts at idx 0.
REQ-030 SHALL check mode switch: auto at idx 5, switch to manual with i_sel=2 -> o_idx = 2 next edge; switch back to auto -> 2 holds 4 cycles, then 3.
